// File: rtl/unary_stream_decoder.sv
// ============================================================================
// Module      : unary_stream_decoder
// Description : Collapses a first/last framed unary bitstream into a saturated
//               binary ones-count with window length and status flags.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module unary_stream_decoder #(
    parameter int LANES      = 16,
    parameter int OUT_W      = 8,
    parameter int MAX_CYCLES = 32
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic                             in_valid,
    input  logic                             in_first,
    input  logic                             in_last,
    input  logic [LANES-1:0]                 in_bits,
    output logic                             in_ready,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [OUT_W-1:0]                 out_count,
    output logic [$clog2(MAX_CYCLES+1)-1:0]  out_len,
    output logic                             out_overflow,
    output logic                             out_trunc,
    output logic                             err_drop
);

    localparam int c_PCW = $clog2(LANES + 1);
    localparam int c_LW  = $clog2(MAX_CYCLES + 1);
    // Sum is wide enough to hold a saturated accumulator plus a full beat.
    localparam int c_SW  = ((OUT_W + 1 > c_PCW) ? OUT_W + 1 : c_PCW) + 1;
    localparam logic [c_SW-1:0] c_SAT = {{(c_SW-OUT_W){1'b0}}, {OUT_W{1'b1}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACC  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            r_state;
    logic [OUT_W:0]    r_acc;
    logic [c_LW-1:0]   r_len;
    logic              r_ovf;

    logic [c_PCW-1:0]  w_pc;
    logic [c_SW-1:0]   w_base;
    logic [c_SW-1:0]   w_sum;
    logic              w_sum_ovf;
    logic [OUT_W:0]    w_acc_next;
    logic              w_ovf_next;
    logic [c_LW-1:0]   w_len_next;
    logic              w_close;
    logic              w_accept;
    logic              w_counts;
    logic              w_drop;

    always_comb begin
        w_pc = '0;
        for (int i = 0; i < LANES; i++) begin
            w_pc = w_pc + c_PCW'(in_bits[i]);
        end
    end

    assign in_ready   = (r_state != S_DONE);
    assign out_valid  = (r_state == S_DONE);
    assign w_accept   = in_valid & in_ready;

    // A first beat always restarts the sum from zero, discarding any partial.
    assign w_base     = in_first ? '0 : c_SW'(r_acc);
    assign w_sum      = w_base + c_SW'(w_pc);
    assign w_sum_ovf  = (w_sum > c_SAT);
    assign w_acc_next = w_sum_ovf ? c_SAT[OUT_W:0] : w_sum[OUT_W:0];
    assign w_ovf_next = w_sum_ovf | (~in_first & r_ovf);
    assign w_len_next = in_first ? c_LW'(1) : (r_len + c_LW'(1));
    assign w_close    = in_last | (w_len_next == c_LW'(MAX_CYCLES));
    assign w_counts   = in_first | (r_state == S_ACC);
    assign w_drop     = in_first ? (r_state == S_ACC) : (r_state == S_IDLE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= S_IDLE;
            r_acc        <= '0;
            r_len        <= '0;
            r_ovf        <= 1'b0;
            out_count    <= '0;
            out_len      <= '0;
            out_overflow <= 1'b0;
            out_trunc    <= 1'b0;
            err_drop     <= 1'b0;
        end else begin
            err_drop <= 1'b0;
            case (r_state)
                S_IDLE, S_ACC: begin
                    if (w_accept) begin
                        err_drop <= w_drop;
                        if (w_counts) begin
                            r_acc <= w_acc_next;
                            r_len <= w_len_next;
                            r_ovf <= w_ovf_next;
                            if (w_close) begin
                                r_state      <= S_DONE;
                                out_count    <= w_acc_next[OUT_W-1:0];
                                out_len      <= w_len_next;
                                out_overflow <= w_ovf_next;
                                out_trunc    <= ~in_last;
                            end else begin
                                r_state <= S_ACC;
                            end
                        end
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: doc/unary_stream_decoder.md
Name: unary_stream_decoder

Overview:
- Receiver end of the unary datapath: takes a framed temporal-unary bitstream (LANES parallel unary lanes per cycle) and collapses it back to a binary count.
- Intended for results leaving unary compute: fanned-out unary/binary MAC lanes, or thermometer streams from external unary generators.
- Counts ones over one window delimited by first/last, then presents a saturated binary result with window length and status flags on a valid/ready output handshake.

Parameters:
- LANES, 16, unary bits presented per input beat.
- OUT_W, 8, width of binary count output.
- MAX_CYCLES, 32, maximum beats per window; the window is force-closed when this is reached.

Ports:
- clk  input  1  clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- in_valid  input  1  input beat valid.
- in_first  input  1  beat opens a window.
- in_last  input  1  beat closes a window.
- in_bits  input  LANES  unary bits of the beat, any bit pattern.
- in_ready  output  1  decoder accepts a beat this cycle.
- out_valid  output  1  result held.
- out_ready  input  1  consumer takes the result.
- out_count  output  OUT_W  saturated ones-count of the window.
- out_len  output  $clog2(MAX_CYCLES+1)  beats in the window.
- out_overflow  output  1  count saturated.
- out_trunc  output  1  window closed by MAX_CYCLES, not by in_last.
- err_drop  output  1  one-cycle pulse when an accepted beat is discarded.

Behaviour:
- Reset (async, any state): state=IDLE; acc, len, overflow, trunc, out_count, out_len, out_overflow, out_trunc all 0; out_valid=0; err_drop=0. in_ready=1 once out of reset.
- A beat is accepted when in_valid & in_ready.
- pc = popcount(in_bits), width $clog2(LANES+1).
- IDLE, in_ready=1:
  - Accepted beat with in_first: acc=pc, len=1, overflow=(pc>2^OUT_W-1).
  - If that beat also has in_last, or MAX_CYCLES==1: go DONE (single-beat window). Otherwise go ACC.
  - Accepted beat without in_first: discarded, err_drop=1 for the cycle after.
- ACC, in_ready=1. Accepted beat:
  - With in_first: restart the window from this beat (same as the IDLE first-beat rule), old partial discarded, err_drop pulse.
  - Otherwise: acc = min(acc+pc, 2^OUT_W-1); overflow sticky-sets if the unsaturated sum exceeds the max; len=len+1.
  - in_last: go DONE, trunc=0.
  - Else if the new len==MAX_CYCLES: go DONE, trunc=1.
  - No beat: hold.
- DONE, in_ready=0:
  - out_valid=1; out_count=acc, out_len=len, out_overflow=overflow, out_trunc=trunc, all stable while out_valid & ~out_ready.
  - out_ready=1: go IDLE next cycle; out_valid deasserts next cycle.
- Output registers update only on entry to DONE. Values persist after the handshake until the next DONE entry; they are qualified by out_valid only.
- Latency: closing beat accepted at cycle N → out_valid=1 at N+1. Minimum window-to-window spacing is 1 idle cycle after the handshake, because in_ready=0 in DONE.
- Beats offered while in_ready=0 are not accepted and not counted; no err_drop.
- Widths: acc is internally OUT_W+1 bits for saturation detection; len never exceeds MAX_CYCLES.

Test Plan:
- Single-beat window: in_first=in_last=1, in_bits=16'hFFFF, out_ready=1 → next cycle out_valid=1, out_count=16, out_len=1, overflow=0, trunc=0; IDLE the following cycle.
- Three beats with popcounts 4, 7, 0 (16'h000F, 16'h7F00, 0), first on beat 1, last on beat 3, with 2 idle cycles between beats 1 and 2 → out_count=11, out_len=3, overflow=0.
- Saturation: 20 beats of 16'hFFFF, last on beat 20 → out_count=255, out_overflow=1, out_len=20, trunc=0.
- Truncation: MAX_CYCLES=32, 40 beats of 16'h0001, first on beat 1, no last:
  - Beat 32 closes the window: out_count=32, out_len=32, out_trunc=1.
  - Beats offered during DONE are not accepted.
  - After the handshake, the remaining beats without first each pulse err_drop.
- Backpressure: result ready with out_ready=0 for 5 cycles → out_valid stays 1, in_ready=0, outputs unchanged, in_valid beats not accepted; out_ready=1 → IDLE next cycle.
- Restart and reset:
  - in_first mid-ACC (acc=9) with pc=3, then last with pc=2 → err_drop pulse, out_count=5, out_len=2.
  - Separately, reset_n low mid-ACC → all outputs 0 immediately, IDLE, no stale result after release.
